// File: rtl/dpi_sync_pkg.sv
// Shared constants for the DPI mode lock detector: FSM encodings, mode index
// width and the default video mode table.
package dpi_sync_pkg;

  localparam int MODE_IDX_W = 3;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  // Entry 0 sits in the least significant slice.
  localparam logic [63:0] DEF_MODE_FREQ  = {16'd51206, 16'd40000, 16'd33264, 16'd25175};
  localparam logic [43:0] DEF_MODE_WIDTH = {11'd1024, 11'd800, 11'd800, 11'd640};

endpackage

// File: rtl/dpi_mode_lock_detector_if.sv
// Measurement input and sync status bundle between the DPI meters and the
// lock detector.
interface dpi_mode_lock_detector_if #(
  parameter int FREQ_W  = 16,
  parameter int WIDTH_W = 11
);
  import dpi_sync_pkg::*;

  logic [FREQ_W-1:0]     freq;
  logic [WIDTH_W-1:0]    width;
  logic                  meas_valid;
  logic                  is_sync;
  logic [MODE_IDX_W-1:0] mode_idx;
  logic                  mode_changed;
  logic                  sync_lost;
  logic [1:0]            state;

  modport master (
    output freq, width, meas_valid,
    input  is_sync, mode_idx, mode_changed, sync_lost, state
  );

  modport slave (
    input  freq, width, meas_valid,
    output is_sync, mode_idx, mode_changed, sync_lost, state
  );

endinterface

// File: rtl/dpi_mode_match.sv
// Single-entry open-window comparator: hit when TARGET-TOL < value < TARGET+TOL,
// with the lower bound clamped at zero and the upper bound kept in W+1 bits.
module dpi_mode_match #(
  parameter int            W      = 16,
  parameter logic [W-1:0]  TARGET = {W{1'b0}},
  parameter int            TOL    = 0
) (
  input  logic [W-1:0] i_value,
  output logic         o_hit
);

  localparam logic [W:0] TGT_X = {1'b0, TARGET};
  localparam logic [W:0] TOL_X = (W+1)'(TOL);
  localparam logic [W:0] LO_X  = (TGT_X >= TOL_X) ? (TGT_X - TOL_X) : {(W+1){1'b0}};
  localparam logic [W:0] HI_X  = TGT_X + TOL_X;

  logic [W:0] w_value_x;

  assign w_value_x = {1'b0, i_value};
  assign o_hit     = (w_value_x > LO_X) && (w_value_x < HI_X);

endmodule

// File: rtl/dpi_mode_lock_detector.sv
// Matches each DPI measurement against the mode table and qualifies the result
// with acquire/hold counting before reporting sync and the locked mode.
module dpi_mode_lock_detector
  import dpi_sync_pkg::*;
#(
  parameter int                           NUM_MODES  = 4,
  parameter int                           FREQ_W     = 16,
  parameter int                           WIDTH_W    = 11,
  parameter logic [NUM_MODES*FREQ_W-1:0]  MODE_FREQ  = DEF_MODE_FREQ,
  parameter logic [NUM_MODES*WIDTH_W-1:0] MODE_WIDTH = DEF_MODE_WIDTH,
  parameter int                           TOL_FREQ   = 256,
  parameter int                           TOL_WIDTH  = 2,
  parameter int                           LOCK_CNT   = 4,
  parameter int                           UNLOCK_CNT = 3
) (
  input logic                     i_clk,
  input logic                     i_rst,
  dpi_mode_lock_detector_if.slave sif
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 3) ? $clog2(CNT_MAX + 1) : 3;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);

  logic [NUM_MODES-1:0]  w_f_hit, w_w_hit, w_hit;
  logic [MODE_IDX_W-1:0] w_hit_idx;
  logic                  w_miss;
  logic                  r_pv, r_miss;
  logic [MODE_IDX_W-1:0] r_hit_idx;
  logic [1:0]            r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx, w_cnt_inc;
  logic [MODE_IDX_W-1:0] r_cand, w_cand_nx, r_mode_idx, w_mode_nx;
  logic                  r_is_sync, w_is_sync_nx, r_mode_changed, r_sync_lost;

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_mode
    dpi_mode_match #(.W(FREQ_W), .TARGET(MODE_FREQ[g*FREQ_W +: FREQ_W]), .TOL(TOL_FREQ))
      u_freq (.i_value(sif.freq), .o_hit(w_f_hit[g]));
    dpi_mode_match #(.W(WIDTH_W), .TARGET(MODE_WIDTH[g*WIDTH_W +: WIDTH_W]), .TOL(TOL_WIDTH))
      u_width (.i_value(sif.width), .o_hit(w_w_hit[g]));
    assign w_hit[g] = w_f_hit[g] & w_w_hit[g];
  end

  assign w_miss = ~|w_hit;

  // Priority encoder: scanning downwards leaves the lowest hitting index.
  always_comb begin
    w_hit_idx = {MODE_IDX_W{1'b0}};
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      w_hit_idx = w_hit[i] ? MODE_IDX_W'(i) : w_hit_idx;
    end
  end

  // Match stage: register the encoded result of every strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pv      <= 1'b0;
      r_miss    <= 1'b0;
      r_hit_idx <= {MODE_IDX_W{1'b0}};
    end else begin
      r_pv      <= sif.meas_valid;
      r_miss    <= w_miss;
      r_hit_idx <= w_hit_idx;
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;

  // Lock qualification; idle cycles leave every register untouched.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_mode_nx  = r_mode_idx;
    if (r_pv) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (r_miss) begin
            w_state_nx = ST_UNLOCKED;
          end else if (LOCK_CNT == 1) begin
            w_state_nx = ST_LOCKED;
            w_cand_nx  = r_hit_idx;
            w_mode_nx  = r_hit_idx;
            w_cnt_nx   = CNT_ZERO;
          end else begin
            w_state_nx = ST_ACQUIRE;
            w_cand_nx  = r_hit_idx;
            w_cnt_nx   = CNT_ONE;
          end
        end
        ST_ACQUIRE: begin
          if (r_miss) begin
            w_state_nx = ST_UNLOCKED;
            w_cnt_nx   = CNT_ZERO;
          end else if (r_hit_idx != r_cand) begin
            w_cand_nx = r_hit_idx;
            w_cnt_nx  = CNT_ONE;
          end else if (w_cnt_inc >= LOCK_C) begin
            w_state_nx = ST_LOCKED;
            w_mode_nx  = r_cand;
            w_cnt_nx   = CNT_ZERO;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        ST_LOCKED: begin
          if (!r_miss && (r_hit_idx == r_mode_idx)) begin
            w_state_nx = ST_LOCKED;
          end else if (UNLOCK_CNT == 1) begin
            w_state_nx = ST_UNLOCKED;
            w_cnt_nx   = CNT_ZERO;
          end else begin
            w_state_nx = ST_HOLD;
            w_cnt_nx   = CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (!r_miss && (r_hit_idx == r_mode_idx)) begin
            w_state_nx = ST_LOCKED;
            w_cnt_nx   = CNT_ZERO;
          end else if (w_cnt_inc >= UNLOCK_C) begin
            w_state_nx = ST_UNLOCKED;
            w_cnt_nx   = CNT_ZERO;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        default: begin
          w_state_nx = ST_UNLOCKED;
          w_cnt_nx   = CNT_ZERO;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  assign w_is_sync_nx = (w_state_nx == ST_LOCKED) || (w_state_nx == ST_HOLD);

  // FSM and registered status outputs; edges of is_sync produce the pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_UNLOCKED;
      r_cnt          <= CNT_ZERO;
      r_cand         <= {MODE_IDX_W{1'b0}};
      r_mode_idx     <= {MODE_IDX_W{1'b0}};
      r_is_sync      <= 1'b0;
      r_mode_changed <= 1'b0;
      r_sync_lost    <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_cand         <= w_cand_nx;
      r_mode_idx     <= w_mode_nx;
      r_is_sync      <= w_is_sync_nx;
      r_mode_changed <= !r_is_sync && w_is_sync_nx;
      r_sync_lost    <= r_is_sync && !w_is_sync_nx;
    end
  end

  assign sif.state        = r_state;
  assign sif.is_sync      = r_is_sync;
  assign sif.mode_idx     = r_mode_idx;
  assign sif.mode_changed = r_mode_changed;
  assign sif.sync_lost    = r_sync_lost;

endmodule

// File: tb/tb_dpi_mode_lock_detector.sv
// Directed and randomized bench for dpi_mode_lock_detector: a default-table DUT
// and an overlapping/clamp-table DUT share stimulus and a behavioural model.
module tb_dpi_mode_lock_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] freq = 16'd0;
  logic [10:0] width = 11'd0;
  logic        meas_valid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  dpi_mode_lock_detector_if #(.FREQ_W(16), .WIDTH_W(11)) bus0 ();
  dpi_mode_lock_detector_if #(.FREQ_W(16), .WIDTH_W(11)) bus1 ();

  assign bus0.freq = freq;  assign bus0.width = width;  assign bus0.meas_valid = meas_valid;
  assign bus1.freq = freq;  assign bus1.width = width;  assign bus1.meas_valid = meas_valid;

  dpi_mode_lock_detector u_dut0 (.i_clk(clk), .i_rst(rst), .sif(bus0));

  dpi_mode_lock_detector #(
    .MODE_FREQ ({16'd51206, 16'd100, 16'd25175, 16'd25175}),
    .MODE_WIDTH({11'd1024, 11'd800, 11'd640, 11'd640})
  ) u_dut1 (.i_clk(clk), .i_rst(rst), .sif(bus1));

  always #5 clk = ~clk;

  logic [1:0] o_state [2];
  logic       o_sync  [2];
  logic [2:0] o_mode  [2];
  logic       o_chg   [2];
  logic       o_lost  [2];
  assign o_state[0] = bus0.state;        assign o_state[1] = bus1.state;
  assign o_sync[0]  = bus0.is_sync;      assign o_sync[1]  = bus1.is_sync;
  assign o_mode[0]  = bus0.mode_idx;     assign o_mode[1]  = bus1.mode_idx;
  assign o_chg[0]   = bus0.mode_changed; assign o_chg[1]   = bus1.mode_changed;
  assign o_lost[0]  = bus0.sync_lost;    assign o_lost[1]  = bus1.sync_lost;

  // Reference tables and model state, one slot per DUT.
  int tf [2][4] = '{'{25175, 33264, 40000, 51206}, '{25175, 25175, 100, 51206}};
  int tw [2][4] = '{'{640, 800, 800, 1024}, '{640, 640, 800, 1024}};
  bit m_sync [2];
  int m_mode [2];
  int m_cand [2];
  int m_run  [2];
  int m_miss [2];
  bit m_chg  [2];
  bit m_lost [2];

  function automatic int ref_match(int t, int f, int w);
    for (int i = 0; i < 4; i++) begin
      int flo = tf[t][i] - 256;
      int wlo = tw[t][i] - 2;
      if (flo < 0) flo = 0;
      if (wlo < 0) wlo = 0;
      if (f > flo && f < tf[t][i] + 256 && w > wlo && w < tw[t][i] + 2) return i;
    end
    return -1;
  endfunction

  task automatic ref_reset();
    for (int t = 0; t < 2; t++) begin
      m_sync[t] = 1'b0; m_mode[t] = 0; m_cand[t] = 0; m_run[t] = 0;
      m_miss[t] = 0; m_chg[t] = 1'b0; m_lost[t] = 1'b0;
    end
  endtask

  // Lock after 4 same-mode matches in a row; unlock after 3 non-matching in a row.
  task automatic ref_step(int t, int idx);
    m_chg[t]  = 1'b0;
    m_lost[t] = 1'b0;
    if (!m_sync[t]) begin
      if (idx < 0) m_run[t] = 0;
      else if (m_run[t] > 0 && idx == m_cand[t]) m_run[t]++;
      else begin m_cand[t] = idx; m_run[t] = 1; end
      if (m_run[t] >= 4) begin
        m_sync[t] = 1'b1; m_mode[t] = m_cand[t]; m_run[t] = 0; m_miss[t] = 0; m_chg[t] = 1'b1;
      end
    end else begin
      if (idx == m_mode[t]) m_miss[t] = 0;
      else begin
        m_miss[t]++;
        if (m_miss[t] >= 3) begin
          m_sync[t] = 1'b0; m_miss[t] = 0; m_run[t] = 0; m_lost[t] = 1'b1;
        end
      end
    end
  endtask

  task automatic ref_apply();
    for (int t = 0; t < 2; t++) ref_step(t, ref_match(t, int'(freq), int'(width)));
  endtask

  function automatic int exp_state(int t);
    if (m_sync[t]) return (m_miss[t] == 0) ? 2 : 3;
    return (m_run[t] == 0) ? 0 : 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("%s d%0d state", ctx, t), o_state[t], exp_state(t));
      chk($sformatf("%s d%0d is_sync", ctx, t), o_sync[t], m_sync[t]);
      chk($sformatf("%s d%0d mode_idx", ctx, t), o_mode[t], m_mode[t]);
      chk($sformatf("%s d%0d mode_changed", ctx, t), o_chg[t], m_chg[t]);
      chk($sformatf("%s d%0d sync_lost", ctx, t), o_lost[t], m_lost[t]);
    end
  endtask

  task automatic check_zero(string ctx);
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("%s d%0d out", ctx, t),
          {o_state[t], o_sync[t], o_mode[t], o_chg[t], o_lost[t]}, 0);
    end
  endtask

  task automatic strobe(int f, int w, string ctx);
    @(negedge clk);
    freq = 16'(f); width = 11'(w); meas_valid = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("%s d%0d pulses idle", ctx, t), {o_chg[t], o_lost[t]}, 0);
    end
    ref_apply();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic burst(int f, int w, int n, string ctx);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      freq = 16'(f); width = 11'(w); meas_valid = 1'b1;
      ref_apply();
    end
    @(negedge clk);
    meas_valid = 1'b0;
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic async_reset(bit inflight, string ctx);
    @(negedge clk);
    if (inflight) begin
      freq = 16'd25175; width = 11'd640; meas_valid = 1'b1;
      @(posedge clk);
      #2;
      meas_valid = 1'b0;
    end else begin
      #2;
    end
    rst = 1'b1;
    #1;
    check_zero({ctx, " during"});
    @(negedge clk);
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    check_zero({ctx, " after"});
    @(negedge clk);
    check_all({ctx, " settled"});
  endtask

  initial begin
    int f, w, src;
    int fe [6] = '{24919, 24920, 25430, 25431, 24918, 25432};
    int we [4] = '{638, 639, 641, 642};
    ref_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset release");

    for (int k = 1; k <= 4; k++) begin
      strobe(25175, 640, $sformatf("t1 strobe%0d", k));
      if (k == 3) chk("t1 sync after 3", o_sync[0], 0);
    end
    chk("t1 sync after 4", o_sync[0], 1);
    chk("t1 mode_idx", o_mode[0], 0);
    chk("t1 mode_changed", o_chg[0], 1);

    foreach (fe[i]) begin
      strobe(fe[i], 640, $sformatf("t2 freq %0d", fe[i]));
      strobe(25175, 640, "t2 restore");
    end
    foreach (we[i]) begin
      strobe(25175, we[i], $sformatf("t2 width %0d", we[i]));
      strobe(25175, 640, "t2 restore");
    end

    strobe(0, 0, "t3 miss1");
    strobe(0, 0, "t3 miss2");
    chk("t3 hold state", o_state[0], 3);
    strobe(25175, 640, "t3 rehit");
    chk("t3 relocked state", o_state[0], 2);
    for (int k = 1; k <= 3; k++) strobe(0, 0, $sformatf("t3 loss%0d", k));
    chk("t3 sync dropped", o_sync[0], 0);
    chk("t3 sync_lost pulse", o_lost[0], 1);

    strobe(25175, 640, "t4 acq1");
    strobe(25175, 640, "t4 acq2");
    strobe(40000, 800, "t4 switch");
    chk("t4 still acquiring", o_state[0], 1);
    for (int k = 1; k <= 3; k++) begin
      strobe(40000, 800, $sformatf("t4 mode2 %0d", k));
      if (k == 2) chk("t4 not yet locked", o_sync[0], 0);
    end
    chk("t4 locked", o_sync[0], 1);
    chk("t4 mode_idx", o_mode[0], 2);

    for (int k = 1; k <= 3; k++) strobe(0, 0, "t5 unlock");
    burst(25175, 640, 4, "t5 burst lock");
    chk("t5 overlap sync", o_sync[1], 1);
    chk("t5 overlap mode_idx", o_mode[1], 0);
    for (int k = 1; k <= 3; k++) strobe(0, 0, "t5 unlock2");
    strobe(0, 800, "t5 clamp f0");
    chk("t5 clamp f0 miss", o_state[1], 0);
    strobe(1, 800, "t5 clamp f1");
    chk("t5 clamp f1 hit", o_state[1], 1);

    strobe(25175, 640, "t6 acq1");
    strobe(25175, 640, "t6 acq2");
    async_reset(1'b0, "t6 rst acquire");
    for (int k = 1; k <= 3; k++) strobe(25175, 640, "t6 relock");
    chk("t6 full count needed", o_sync[0], 0);
    strobe(25175, 640, "t6 relock4");
    chk("t6 relocked", o_sync[0], 1);
    async_reset(1'b1, "t6 rst locked");

    src = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(7) == 0) src = int'($urandom_range(3));
      case ($urandom_range(9))
        0: begin f = int'($urandom_range(65535)); w = int'($urandom_range(2047)); end
        1: begin
          f = tf[0][src] + (($urandom_range(1) == 1) ? 256 : -256) + int'($urandom_range(2)) - 1;
          w = tw[0][src];
        end
        2: begin f = int'($urandom_range(300)); w = 799 + int'($urandom_range(2)); end
        3: begin f = tf[0][src]; w = tw[0][src] + int'($urandom_range(6)) - 3; end
        default: begin
          f = tf[0][src] + int'($urandom_range(500)) - 250;
          w = tw[0][src] + int'($urandom_range(2)) - 1;
        end
      endcase
      strobe(f, w, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
